ghost_motion_ctrl: RTL and testbench
====================================

Name: ghost_motion_ctrl

Overview:
- Downstream stage of each per-ghost behaviour block (chase, ambush, shy/run-away variants).
- The behaviour block emits a 2-bit dirToMove. This block owns the ghost's authoritative tile and pixel position and steps it one pixel per movement tick.
- At each tile centre it pulses update to the behaviour block, latches the returned direction, and validates it against the maze wall flags.
- Position outputs feed the renderer, the collision checker, and the behaviour block's ghostPos inputs.

Parameters:
- MAP_W, 28, maze width in tiles.
- MAP_H, 31, maze height in tiles.
- TILE_PX, 8, pixels per tile; power of two, at least 2.
- X_W, 5, tile X coordinate width.
- Y_W, 5, tile Y coordinate width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  single-cycle movement strobe; one pixel step per accepted tick.
- intPosX  in  X_W  start tile X, sampled during reset.
- intPosY  in  Y_W  start tile Y, sampled during reset.
- dirToMove  in  2  requested direction from behaviour block (00 U, 01 R, 10 D, 11 L).
- canMoveU, canMoveR, canMoveD, canMoveL  in  1 each  wall-free flags for the current tile's neighbours.
- update  out  1  one-cycle request to the behaviour block for a new direction.
- ghostPosX  out  X_W  current tile X.
- ghostPosY  out  Y_W  current tile Y.
- ghostPixX  out  X_W+log2(TILE_PX)  pixel X.
- ghostPixY  out  Y_W+log2(TILE_PX)  pixel Y.
- curDir  out  2  direction currently being travelled.
- moving  out  1  high while in MOVE.

Behaviour:
Reset (synchronous, active-high):
- ghostPosX=intPosX, ghostPosY=intPosY, subCnt=0, curDir=00, update=0, moving=0, state=DECIDE.
- Reset asserted mid-move discards all motion and re-centres the ghost on the start tile the next cycle.

State machine (states DECIDE, LATCH, MOVE, STALL):
- DECIDE: update=1 for exactly one cycle, then go to LATCH. Ticks are ignored.
- LATCH: sample dirToMove; this is one cycle of latency after update. Ticks are ignored.
  - If the flag for dirToMove is 1: curDir=dirToMove, go to MOVE.
  - Else if the flag for the existing curDir is 1: keep curDir, go to MOVE.
  - Else: go to STALL.
- MOVE: moving=1. On each tick, subCnt increments.
  - When subCnt reaches TILE_PX-1 and another tick arrives: subCnt=0, tile coordinate steps by one in curDir, go to DECIDE.
  - The tile and pixel update in the same cycle as the tick (zero-cycle latency after the tick edge).
- STALL: moving=0, position held. On the next tick, go to DECIDE.
  - That tick does not move the ghost.

Pixel mapping (both axes, pixel = tile*TILE_PX plus an offset on the axis of travel):
- U: Y axis, offset -subCnt.
- D: Y axis, offset +subCnt.
- L: X axis, offset -subCnt.
- R: X axis, offset +subCnt.
- The axis not being travelled has offset 0.
- Pixel offsets wrap modulo the pixel width.

Tile stepping and wrap-around:
- R from MAP_W-1 wraps to 0.
- L from 0 wraps to MAP_W-1.
- While mid-tunnel at X=0 moving L, the pixel value wraps to the right edge.
- No Y wrap. U at Y=0 or D at Y=MAP_H-1 is treated as blocked regardless of the flag.

Timing rules:
- canMove* are consulted only in LATCH. They are not consulted mid-tile.
- A tick coincident with reset is ignored.
- update is never high for two consecutive cycles.
- Steady-state cadence with a tick on every cycle: DECIDE, then LATCH, then TILE_PX MOVE ticks. That is TILE_PX+2 cycles per tile.

Optional Feature:
Macro GHOST_NO_REVERSE_EN.
- Defined: in LATCH, a dirToMove equal to the opposite of curDir is rejected like a blocked direction, unless all three non-reverse flags are 0 (dead end). In a dead end the reverse is accepted.
- Undefined: reversal is accepted whenever its flag is 1.
- In both cases, the first decision after reset accepts any open direction.

Test Plan:
- Reset with intPos=(13,11), TILE_PX=8 -> pos (13,11), pix (104,88), update=0; cycle after reset release update=1 for exactly one cycle.
- dirToMove=01, canMoveR=1, eight ticks -> pixX steps 105..111 then pos X=14, pixX=112, update pulses; curDir=01 throughout.
- Request L with canMoveL=0 while curDir=R and canMoveR=1 -> curDir stays 01 and the ghost continues right; with all flags 0 -> STALL, moving=0, DECIDE re-entered after the next tick.
- Tunnel: pos X=0, dirToMove=11, canMoveL=1, eight ticks -> pos X=27; mirrored case: X=27 moving R -> X=0.
- Reset asserted after three ticks into a tile -> next cycle pos = intPos, subCnt=0, pix aligned, moving=0.
- With GHOST_NO_REVERSE_EN, curDir=01, request 11 with canMoveL=1 and canMoveR=1 -> curDir stays 01; with canMoveU/R/D=0 -> curDir becomes 11.

Source files
------------

// File: rtl/ghost_motion_ctrl.sv
// ghost_motion_ctrl: owns a ghost's tile and pixel position. At each tile centre
// it requests a direction from the behaviour block, validates it against the
// wall flags and steps one pixel per movement tick.
// Optional build macro GHOST_NO_REVERSE_EN: rejects 180-degree turns except at
// dead ends. The first decision after reset is always exempt.
module ghost_motion_ctrl #(
  parameter int MAP_W   = 28,
  parameter int MAP_H   = 31,
  parameter int TILE_PX = 8,
  parameter int X_W     = 5,
  parameter int Y_W     = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic [X_W-1:0]                intPosX,
  input  logic [Y_W-1:0]                intPosY,
  input  logic [1:0]                    dirToMove,
  input  logic                          canMoveU,
  input  logic                          canMoveR,
  input  logic                          canMoveD,
  input  logic                          canMoveL,
  output logic                          update,
  output logic [X_W-1:0]                ghostPosX,
  output logic [Y_W-1:0]                ghostPosY,
  output logic [X_W+$clog2(TILE_PX)-1:0] ghostPixX,
  output logic [Y_W+$clog2(TILE_PX)-1:0] ghostPixY,
  output logic [1:0]                    curDir,
  output logic                          moving
);

  localparam int SUB_W = $clog2(TILE_PX);

  typedef enum logic [1:0] {DIR_U = 2'b00, DIR_R = 2'b01, DIR_D = 2'b10, DIR_L = 2'b11} dir_t;
  typedef enum logic [1:0] {ST_DECIDE, ST_LATCH, ST_MOVE, ST_STALL} state_t;

  state_t           state;
  dir_t             cur_dir;
  logic [SUB_W-1:0] sub_cnt;
  logic [3:0]       open_vec;   // indexed by direction code
  logic [1:0]       rev_dir;
  logic             req_ok;
  logic             keep_ok;
  logic [X_W-1:0]   next_x;
  logic [Y_W-1:0]   next_y;
`ifdef GHOST_NO_REVERSE_EN
  logic             first_dec;
`endif

  assign curDir = cur_dir;

  // Legal-direction evaluation; the maze edges in Y are hard walls.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    open_vec[DIR_U] = canMoveU && (ghostPosY != '0);
    open_vec[DIR_R] = canMoveR;
    open_vec[DIR_D] = canMoveD && (ghostPosY != Y_W'(MAP_H - 1));
    open_vec[DIR_L] = canMoveL;
    rev_dir = cur_dir ^ 2'b10;
    req_ok  = open_vec[dirToMove];
    keep_ok = open_vec[cur_dir];
`ifdef GHOST_NO_REVERSE_EN
    // Reverse only allowed at a dead end (all other neighbours walled).
    if (!first_dec && (dirToMove == rev_dir) &&
        |(open_vec & ~(4'b0001 << rev_dir)))
      req_ok = 1'b0;
`endif
  end

  // Neighbouring tile in the current direction, with the horizontal tunnel wrap.
  always_comb begin
    next_x = ghostPosX;
    next_y = ghostPosY;
    case (cur_dir)
      DIR_R: next_x = (ghostPosX == X_W'(MAP_W - 1)) ? '0 : ghostPosX + 1'b1;
      DIR_L: next_x = (ghostPosX == '0) ? X_W'(MAP_W - 1) : ghostPosX - 1'b1;
      DIR_U: next_y = ghostPosY - 1'b1;
      DIR_D: next_y = ghostPosY + 1'b1;
      default: ;
    endcase
  end

  // Pixel position: tile origin plus the signed sub-tile offset on the travel axis.
  always_comb begin
    ghostPixX = {ghostPosX, {SUB_W{1'b0}}};
    ghostPixY = {ghostPosY, {SUB_W{1'b0}}};
    case (cur_dir)
      DIR_R: ghostPixX = {ghostPosX, {SUB_W{1'b0}}} + {{X_W{1'b0}}, sub_cnt};
      DIR_L: ghostPixX = {ghostPosX, {SUB_W{1'b0}}} - {{X_W{1'b0}}, sub_cnt};
      DIR_D: ghostPixY = {ghostPosY, {SUB_W{1'b0}}} + {{Y_W{1'b0}}, sub_cnt};
      DIR_U: ghostPixY = {ghostPosY, {SUB_W{1'b0}}} - {{Y_W{1'b0}}, sub_cnt};
      default: ;
    endcase
  end

  // Movement state machine with registered update/moving outputs.
  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_DECIDE;
      ghostPosX <= intPosX;
      ghostPosY <= intPosY;
      sub_cnt   <= '0;
      cur_dir   <= DIR_U;
      update    <= 1'b0;
      moving    <= 1'b0;
`ifdef GHOST_NO_REVERSE_EN
      first_dec <= 1'b1;
`endif
    end else begin
      update <= 1'b0;
      case (state)
        ST_DECIDE: begin
          update <= 1'b1;
          state  <= ST_LATCH;
        end
        ST_LATCH: begin
`ifdef GHOST_NO_REVERSE_EN
          first_dec <= 1'b0;
`endif
          if (req_ok) begin
            cur_dir <= dir_t'(dirToMove);
            moving  <= 1'b1;
            state   <= ST_MOVE;
          end else if (keep_ok) begin
            moving  <= 1'b1;
            state   <= ST_MOVE;
          end else begin
            state   <= ST_STALL;
          end
        end
        ST_MOVE: begin
          if (tick) begin
            if (sub_cnt == SUB_W'(TILE_PX - 1)) begin
              sub_cnt   <= '0;
              ghostPosX <= next_x;
              ghostPosY <= next_y;
              moving    <= 1'b0;
              state     <= ST_DECIDE;
            end else begin
              sub_cnt <= sub_cnt + 1'b1;
            end
          end
        end
        ST_STALL: begin
          if (tick) state <= ST_DECIDE;
        end
        default: state <= ST_DECIDE;
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_motion_ctrl.sv
// Directed bench for ghost_motion_ctrl (default parameters, TILE_PX=8).
module tb_ghost_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset, tick;
  logic [4:0] intPosX, intPosY;
  logic [1:0] dirToMove;
  logic       canMoveU, canMoveR, canMoveD, canMoveL;
  logic       update, moving;
  logic [4:0] ghostPosX, ghostPosY;
  logic [7:0] ghostPixX, ghostPixY;
  logic [1:0] curDir;

  int checks   = 0;
  int failures = 0;

`ifdef GHOST_NO_REVERSE_EN
  localparam logic [1:0] REV_EXP = 2'b01;
  localparam int         PIX_AFTER3 = 123;
`else
  localparam logic [1:0] REV_EXP = 2'b11;
  localparam int         PIX_AFTER3 = 117;
`endif

  ghost_motion_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick),
    .intPosX(intPosX), .intPosY(intPosY), .dirToMove(dirToMove),
    .canMoveU(canMoveU), .canMoveR(canMoveR), .canMoveD(canMoveD), .canMoveL(canMoveL),
    .update(update), .ghostPosX(ghostPosX), .ghostPosY(ghostPosY),
    .ghostPixX(ghostPixX), .ghostPixY(ghostPixY), .curDir(curDir), .moving(moving)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply tick for one clock edge, then sample 1 ns after it.
  task automatic step(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic flags(input logic u, input logic r, input logic d, input logic l);
    canMoveU = u; canMoveR = r; canMoveD = d; canMoveL = l;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; intPosX = 5'd13; intPosY = 5'd11;
    dirToMove = 2'b01; flags(0, 1, 0, 0);

    // Reset, including a tick coincident with reset.
    step(0);
    step(1);
    check("rst_posx", ghostPosX, 13);
    check("rst_posy", ghostPosY, 11);
    check("rst_pixx", ghostPixX, 104);
    check("rst_pixy", ghostPixY, 88);
    check("rst_update", update, 0);
    check("rst_moving", moving, 0);
    check("rst_curdir", curDir, 0);

    // First decision: move right from (13,11).
    reset = 1'b0;
    step(0);
    check("upd_first", update, 1);
    step(0);
    check("upd_one_cycle", update, 0);
    check("latch_r_dir", curDir, 1);
    check("latch_r_moving", moving, 1);
    for (int i = 1; i < 8; i++) begin
      step(1);
      check("move_r_pixx", ghostPixX, 104 + i);
      check("move_r_posx", ghostPosX, 13);
    end
    step(1);
    check("tile_r_posx", ghostPosX, 14);
    check("tile_r_pixx", ghostPixX, 112);
    check("tile_r_moving", moving, 0);
    step(0);
    check("upd_tile2", update, 1);

    // Blocked L request while R is open: keep going right.
    dirToMove = 2'b11; flags(0, 1, 0, 0);
    step(0);
    check("keep_dir", curDir, 1);
    check("keep_moving", moving, 1);
    step(1);
    check("keep_pixx", ghostPixX, 113);
    for (int i = 0; i < 7; i++) step(1);
    check("keep_posx", ghostPosX, 15);
    check("keep_pixx_end", ghostPixX, 120);

    // All flags closed: stall until a tick.
    step(0);
    check("upd_stall", update, 1);
    dirToMove = 2'b00; flags(0, 0, 0, 0);
    step(0);
    check("stall_moving", moving, 0);
    check("stall_dir", curDir, 1);
    step(0);
    check("stall_hold_upd", update, 0);
    step(1);
    check("stall_tick_posx", ghostPosX, 15);
    check("stall_tick_pixx", ghostPixX, 120);
    check("stall_tick_upd", update, 0);
    step(0);
    check("stall_redecide", update, 1);

    // Reverse request with L and R both open.
    dirToMove = 2'b11; flags(0, 1, 0, 1);
    step(0);
    check("rev_dir", curDir, REV_EXP);
    check("rev_moving", moving, 1);
    step(1); step(1); step(1);
    check("rev_pixx3", ghostPixX, PIX_AFTER3);

    // Reset mid-move onto the tunnel tile; tick coincident with reset.
    reset = 1'b1; intPosX = 5'd0; intPosY = 5'd11;
    step(1);
    check("midrst_posx", ghostPosX, 0);
    check("midrst_posy", ghostPosY, 11);
    check("midrst_pixx", ghostPixX, 0);
    check("midrst_pixy", ghostPixY, 88);
    check("midrst_moving", moving, 0);
    check("midrst_curdir", curDir, 0);

    // Tunnel: left from X=0.
    reset = 1'b0; dirToMove = 2'b11; flags(0, 0, 0, 1);
    step(0);
    check("tun_l_upd", update, 1);
    step(0);
    check("tun_l_dir", curDir, 3);
    step(1);
    check("tun_l_pixwrap", ghostPixX, 255);
    for (int i = 0; i < 7; i++) step(1);
    check("tun_l_posx", ghostPosX, 27);
    check("tun_l_pixx", ghostPixX, 216);

    // Mirror: right from X=27 (dead end, so reverse accepted in both builds).
    step(0);
    check("tun_r_upd", update, 1);
    dirToMove = 2'b01; flags(0, 1, 0, 0);
    step(0);
    check("tun_r_dir", curDir, 1);
    step(1);
    check("tun_r_pix1", ghostPixX, 217);
    for (int i = 0; i < 7; i++) step(1);
    check("tun_r_posx", ghostPosX, 0);
    check("tun_r_pixx", ghostPixX, 0);

    // Top edge: U blocked at Y=0 regardless of flag.
    reset = 1'b1; intPosX = 5'd5; intPosY = 5'd0;
    step(0);
    reset = 1'b0; dirToMove = 2'b00; flags(1, 0, 1, 0);
    step(0);
    step(0);
    check("ytop_stall_moving", moving, 0);
    check("ytop_stall_dir", curDir, 0);
    step(1);
    step(0);
    check("ytop_upd", update, 1);
    dirToMove = 2'b10;
    step(0);
    check("ytop_d_dir", curDir, 2);
    step(1);
    check("ytop_d_pixy", ghostPixY, 1);
    check("ytop_d_pixx", ghostPixX, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
